// File: rtl/rv_stage_sequencer.sv
// rv_stage_sequencer
//   Multi-cycle control sequencer for the RV32I core. It steps each instruction
//   through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK using a done/stall handshake
//   with the datapath. It also handles flush redirect, illegal-opcode and
//   watchdog traps, halt at instruction boundaries, optional WRITEBACK skip for
//   rd=x0, and counts retired instructions.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   stage_done, stall   datapath handshake for the current stage
//   flush               redirect to FETCH (working states only)
//   opcode, rd_zero     decoded instruction fields
//   halt_req            level; halt at the next instruction boundary
//   trap_ack            leave TRAP
//   state, state_d1     current state, and current state delayed one cycle
//   next_state          combinational next state
//   stage_start         first cycle of every state visit
//   trap, trap_cause    in TRAP; cause 1 = illegal opcode, 2 = watchdog
//   retire, instret_cnt retire pulse and retired-instruction count
//   halted              in HALT
module rv_stage_sequencer #(
    parameter int TIMEOUT    = 64,
    parameter int TIMEOUT_W  = 8,
    parameter int SKIP_WB_X0 = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stage_done,
    input  logic             stall,
    input  logic             flush,
    input  logic [6:0]       opcode,
    input  logic             rd_zero,
    input  logic             halt_req,
    input  logic             trap_ack,
    output logic [2:0]       state,
    output logic [2:0]       state_d1,
    output logic [2:0]       next_state,
    output logic             stage_start,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic             retire,
    output logic [CNT_W-1:0] instret_cnt,
    output logic             halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t               state_q, state_nx, d1_q, target;
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic [1:0]           cause_nx;
    logic                 retire_nx, working, wait_cyc, legal, skip_wb, visit_change;

    always_comb begin
        legal = (opcode == OP_LUI)    || (opcode == OP_AUIPC) || (opcode == OP_JAL)   ||
                (opcode == OP_JALR)   || (opcode == OP_BRANCH) || (opcode == OP_LOAD) ||
                (opcode == OP_STORE)  || (opcode == OP_IMM)   || (opcode == OP_OP);
        skip_wb = (SKIP_WB_X0 != 0) && rd_zero;
    end

    // Target of a normal advance from each working state (before halt override).
    always_comb begin
        target = S_FETCH;
        case (state_q)
            S_FETCH:  target = S_DECODE;
            S_DECODE: target = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (opcode == OP_BRANCH)                           target = S_FETCH;
                else if (opcode == OP_LOAD || opcode == OP_STORE)  target = S_MEM;
                else                                               target = skip_wb ? S_FETCH : S_WB;
            end
            S_MEM:    target = (opcode == OP_STORE || skip_wb) ? S_FETCH : S_WB;
            default:  target = S_FETCH;
        endcase
    end

    always_comb begin
        state_nx  = state_q;
        cause_nx  = 2'd0;
        retire_nx = 1'b0;
        working   = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                    (state_q == S_MEM)   || (state_q == S_WB);
        wait_cyc  = working && !stall && !stage_done;
        if (working) begin
            if (flush) begin
                state_nx = S_FETCH;
            end else if ((TIMEOUT != 0) && wait_cyc && (wd_cnt == WD_LAST)) begin
                state_nx = S_TRAP;
                cause_nx = 2'd2;
            end else if (!stall && stage_done) begin
                state_nx = target;
                if (target == S_TRAP)
                    cause_nx = 2'd1;
                else if (target == S_FETCH && halt_req)
                    state_nx = S_HALT;
                // Only a normal advance back to an instruction boundary retires.
                retire_nx = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) &&
                            ((state_nx == S_FETCH) || (state_nx == S_HALT));
            end
        end else if (state_q == S_TRAP) begin
            if (trap_ack) state_nx = S_FETCH;
        end else if (state_q == S_HALT) begin
            if (!halt_req) state_nx = S_FETCH;
        end else begin
            state_nx = S_FETCH;     // encoding 7 is unreachable; recover to FETCH
        end
    end

    // A flush while already in FETCH is a fresh visit even though the code is unchanged.
    assign visit_change = (state_nx != state_q) || (working && flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            d1_q        <= S_WB;
            stage_start <= 1'b1;
            trap_cause  <= 2'd0;
            retire      <= 1'b0;
            instret_cnt <= '0;
            wd_cnt      <= '0;
        end else begin
            state_q     <= state_nx;
            d1_q        <= state_q;
            stage_start <= visit_change;
            retire      <= retire_nx;
            if (retire_nx)
                instret_cnt <= instret_cnt + CNT_W'(1);
            if (state_nx == S_TRAP && state_q != S_TRAP)
                trap_cause <= cause_nx;
            else if (state_nx != S_TRAP)
                trap_cause <= 2'd0;
            if (visit_change)
                wd_cnt <= '0;
            else if (wait_cyc)
                wd_cnt <= wd_cnt + TIMEOUT_W'(1);
        end
    end

    assign state      = state_q;
    assign state_d1   = d1_q;
    assign next_state = state_nx;
    assign trap       = (state_q == S_TRAP);
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_rv_stage_sequencer.sv
// Directed bench for rv_stage_sequencer (TIMEOUT=4, SKIP_WB_X0=1, CNT_W=4).
module tb_rv_stage_sequencer;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk, rst_n, stage_done, stall, flush, rd_zero, halt_req, trap_ack;
    logic [6:0] opcode;
    logic [2:0] state, state_d1, next_state;
    logic       stage_start, trap, retire, halted;
    logic [1:0] trap_cause;
    logic [3:0] instret_cnt;

    int nchk = 0;
    int nerr = 0;

    rv_stage_sequencer #(.TIMEOUT(4), .TIMEOUT_W(8), .SKIP_WB_X0(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .stage_done(stage_done), .stall(stall), .flush(flush),
        .opcode(opcode), .rd_zero(rd_zero), .halt_req(halt_req), .trap_ack(trap_ack),
        .state(state), .state_d1(state_d1), .next_state(next_state),
        .stage_start(stage_start), .trap(trap), .trap_cause(trap_cause),
        .retire(retire), .instret_cnt(instret_cnt), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stage_done = 1'b0; stall = 1'b0; flush = 1'b0;
        opcode = OP_OP; rd_zero = 1'b0; halt_req = 1'b0; trap_ack = 1'b0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_state_d1", state_d1, 4);
        chk("rst_stage_start", stage_start, 1);
        chk("rst_trap", trap, 0);
        chk("rst_cause", trap_cause, 0);
        chk("rst_retire", retire, 0);
        chk("rst_instret", instret_cnt, 0);
        chk("rst_halted", halted, 0);
        chk("rst_wd", dut.wd_cnt, 0);
        rst_n = 1'b1;

        // R-type rd=x5, one cycle per stage: 0,1,2,4,0
        stage_done = 1'b1; #1;
        chk("r_next0", next_state, 1);
        tick(); chk("r_s1", state, 1); chk("r_d1", state_d1, 0); chk("r_start1", stage_start, 1);
        tick(); chk("r_s2", state, 2);
        tick(); chk("r_s4", state, 4); chk("r_noret", retire, 0);
        tick(); chk("r_s0", state, 0); chk("r_ret", retire, 1); chk("r_cnt", instret_cnt, 1);
        // rd=x0: writeback skipped, 0,1,2,0
        rd_zero = 1'b1;
        tick(); chk("x0_s1", state, 1); chk("x0_ret_pulse", retire, 0);
        tick(); chk("x0_s2", state, 2);
        tick(); chk("x0_s0", state, 0); chk("x0_ret", retire, 1); chk("x0_cnt", instret_cnt, 2);

        // LOAD with MEMORY done delayed: stall, stall, wait, done
        rd_zero = 1'b0; opcode = OP_LOAD;
        tick(); tick(); tick(); chk("ld_mem", state, 3);
        stage_done = 1'b0; stall = 1'b1;
        tick(); chk("ld_c1", state, 3); chk("ld_c1_start", stage_start, 0); chk("ld_c1_wd", dut.wd_cnt, 0);
        tick(); chk("ld_c2", state, 3);
        stall = 1'b0;
        tick(); chk("ld_c3", state, 3); chk("ld_wd_peak", dut.wd_cnt, 1);
        stage_done = 1'b1;
        tick(); chk("ld_wb", state, 4); chk("ld_wd_clr", dut.wd_cnt, 0);
        tick(); chk("ld_f", state, 0); chk("ld_cnt", instret_cnt, 3);

        // Illegal opcode trap
        opcode = OP_BAD;
        tick(); chk("il_dec", state, 1); chk("il_next", next_state, 5);
        tick(); chk("il_trap", trap, 1); chk("il_cause", trap_cause, 1); chk("il_noret", retire, 0);
        tick(); chk("il_hold", state, 5); chk("il_cause_hold", trap_cause, 1);
        trap_ack = 1'b1; #1;
        chk("il_ack_next", next_state, 0);
        tick(); chk("il_exit", state, 0); chk("il_cause_clr", trap_cause, 0); chk("il_cnt", instret_cnt, 3);
        trap_ack = 1'b0;

        // Watchdog: EXECUTE with no done traps 4 wait cycles after entry
        opcode = OP_OP;
        tick(); tick(); chk("wd_exec", state, 2);
        stage_done = 1'b0;
        tick(); tick(); tick(); chk("wd_w3", state, 2); chk("wd_next", next_state, 5);
        tick(); chk("wd_trap", state, 5); chk("wd_cause", trap_cause, 2); chk("wd_noret", retire, 0);
        trap_ack = 1'b1;
        tick(); chk("wd_exit", state, 0);
        trap_ack = 1'b0; stage_done = 1'b1;
        // Same with stall held: never traps
        tick(); tick(); chk("wds_exec", state, 2);
        stage_done = 1'b0; stall = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("wds_hold", state, 2); chk("wds_notrap", trap, 0); chk("wds_wd", dut.wd_cnt, 0);
        stall = 1'b0; stage_done = 1'b1;
        tick(); chk("wds_wb", state, 4);
        tick(); chk("wds_f", state, 0); chk("wds_cnt", instret_cnt, 4);

        // Flush in MEMORY while stalled
        opcode = OP_STORE;
        tick(); tick(); tick(); chk("fl_mem", state, 3);
        stall = 1'b1; flush = 1'b1; #1;
        chk("fl_next", next_state, 0);
        tick(); chk("fl_f", state, 0); chk("fl_start", stage_start, 1);
        chk("fl_cnt", instret_cnt, 4); chk("fl_noret", retire, 0);
        // Flush in FETCH is a fresh visit
        stall = 1'b0; stage_done = 1'b0;
        tick(); chk("flf_f", state, 0); chk("flf_start", stage_start, 1);
        flush = 1'b0;
        tick(); chk("flf_start0", stage_start, 0);

        // Halt request during EXECUTE of a STORE
        stage_done = 1'b1;
        tick(); tick(); chk("h_exec", state, 2);
        halt_req = 1'b1;
        tick(); chk("h_mem", state, 3);
        tick(); chk("h_halt", state, 6); chk("h_halted", halted, 1); chk("h_ret", retire, 1);
        chk("h_cnt", instret_cnt, 5);
        tick(); chk("h_stay", state, 6); chk("h_ret0", retire, 0);
        halt_req = 1'b0;
        tick(); chk("h_exit", state, 0); chk("h_unhalt", halted, 0); chk("h_start", stage_start, 1);

        // 11 branches: 5 + 11 = 16 wraps to 0 with a 4-bit counter
        opcode = OP_BRANCH;
        for (int i = 0; i < 33; i++) tick();
        chk("wrap_state", state, 0); chk("wrap_cnt", instret_cnt, 0);
        tick(); tick(); tick(); chk("br_cnt", instret_cnt, 1);

        // Asynchronous reset mid-instruction
        tick(); chk("ar_pre", state, 1);
        #2 rst_n = 1'b0; #1;
        chk("ar_state", state, 0); chk("ar_d1", state_d1, 4);
        chk("ar_start", stage_start, 1); chk("ar_cnt", instret_cnt, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
